id_stage: RTL

Instruction-decode stage of the 5-stage MIPS32 pipeline; producer side of the ID/EX interface consumed by the execute stage. Decodes the fetched instruction, reads two operands from the 32x32 register file, sign-extends the immediate, and registers operands plus the main-control signal set into the ID/EX pipeline register. Detects load-use hazards, stalls fetch, and inserts bubbles; accepts the writeback port and flushes from branch resolution.

---
 rtl/mips_pkg.sv | 32 +++
 rtl/reg_file.sv | 19 +
 rtl/id_stage.sv | 80 ++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: opcodes, ALUOp encodings and the main-control bundle shared across pipeline stages
package mips_pkg;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic [1:0] alu_op;
  } ctrl_t;
  function automatic logic is_legal(input logic [5:0] op);
    return op == OP_RTYPE || op == OP_LW || op == OP_SW || op == OP_BEQ || op == OP_ADDI;
  endfunction
  function automatic ctrl_t decode(input logic [5:0] op);
    return op == OP_RTYPE ? ctrl_t'{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, ALU_FUNCT} :
           op == OP_LW    ? ctrl_t'{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, ALU_ADD} :
           op == OP_SW    ? ctrl_t'{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ALU_ADD} :
           op == OP_BEQ   ? ctrl_t'{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ALU_SUB} :
           op == OP_ADDI  ? ctrl_t'{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, ALU_ADD} :
                            ctrl_t'('0);
  endfunction
endpackage

// File: rtl/reg_file.sv
// reg_file: 32x32 register file, two combinational reads with write-through, one synchronous write, r0 hardwired zero
module reg_file (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  ra,
  input  logic [4:0]  rb,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  output logic [31:0] rd_a,
  output logic [31:0] rd_b
);
  logic [31:0] regs [32];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int i = 0; i < 32; i++) regs[i] <= '0;
    else if (we && wa != 5'd0) regs[wa] <= wd;
  assign rd_a = ra == 5'd0 ? '0 : (we && wa == ra) ? wd : regs[ra];
  assign rd_b = rb == 5'd0 ? '0 : (we && wa == rb) ? wd : regs[rb];
endmodule

// File: rtl/id_stage.sv
// id_stage: MIPS32 decode stage with register read, load-use stall and ID/EX pipeline register
module id_stage import mips_pkg::*; (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        instr_valid,
  input  logic        flush,
  input  logic        wb_we,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic [31:0] srcA,
  output logic [31:0] srcB,
  output logic [31:0] immediate_ext,
  output logic        RegDst,
  output logic        ALUSrc,
  output logic        MemtoReg,
  output logic        RegWrite,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        Branch,
  output logic [1:0]  ALUOp,
  output logic [5:0]  funct,
  output logic [4:0]  ex_rt,
  output logic [4:0]  ex_rd,
  output logic        ex_valid,
  output logic        stall,
  output logic        illegal_instr
);
  logic [5:0]  op;
  logic [4:0]  rs, rt;
  logic [31:0] rd_a, rd_b;
  ctrl_t       ctrl, ex_ctrl;
  logic        legal, uses_rt, bubble;
  assign op = instr[31:26];
  assign rs = instr[25:21];
  assign rt = instr[20:16];
  reg_file u_rf (
    .clk(clk), .rst_n(rst_n), .ra(rs), .rb(rt),
    .we(wb_we), .wa(wb_addr), .wd(wb_data), .rd_a(rd_a), .rd_b(rd_b)
  );
  // lw/addi use rt only as a destination, so it cannot create a load-use dependency
  always_comb begin
    ctrl = decode(op);
    legal = is_legal(op);
    uses_rt = op == OP_RTYPE || op == OP_SW || op == OP_BEQ;
    stall = ex_valid & ex_ctrl.mem_read & instr_valid & !flush & (ex_rt != 5'd0) &
            ((ex_rt == rs) | (uses_rt & (ex_rt == rt)));
    bubble = flush | stall | !instr_valid;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n || bubble) begin
      srcA <= '0;
      srcB <= '0;
      immediate_ext <= '0;
      ex_ctrl <= '0;
      funct <= '0;
      ex_rt <= '0;
      ex_rd <= '0;
      ex_valid <= 1'b0;
      illegal_instr <= 1'b0;
    end else begin
      srcA <= rd_a;
      srcB <= rd_b;
      immediate_ext <= {{16{instr[15]}}, instr[15:0]};
      ex_ctrl <= ctrl;
      funct <= instr[5:0];
      ex_rt <= rt;
      ex_rd <= instr[15:11];
      ex_valid <= legal;
      illegal_instr <= !legal;
    end
  assign RegDst   = ex_ctrl.reg_dst;
  assign ALUSrc   = ex_ctrl.alu_src;
  assign MemtoReg = ex_ctrl.mem_to_reg;
  assign RegWrite = ex_ctrl.reg_write;
  assign MemRead  = ex_ctrl.mem_read;
  assign MemWrite = ex_ctrl.mem_write;
  assign Branch   = ex_ctrl.branch;
  assign ALUOp    = ex_ctrl.alu_op;
endmodule
